id_ex_pipe_reg: RTL
===================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID->EX pipeline register. Sits directly downstream of the decode control unit.
//  Registers the decoded control bundle, operands, immediate, PC and register indices into EX.
//  Detects load-use hazards, inserts one bubble per hazard and raises a stall for PC/IF-ID.
//  Honours flush (taken branch/jump from EX) and external hold. Counts inserted bubbles.
// PARAMETERS
//  XLEN   32  datapath width (PC, operands, immediate)
//  CNT_W  16  width of bubble counter
// PORTS
//  clk           in   1      clock, all state updates on rising edge
//  rst           in   1      synchronous, active-high reset
//  id_valid      in   1      ID holds a real instruction
//  id_ctrl       in   17     {LoadSize[16:15],MemSize[14:13],ALUOp[12:10],JALR,BranchType,RegDst,ALUSrc,IsBranch,MemWriteEn,MemReadEn,JAL,MemtoReg,RegWriteEn[0]}
//  id_pc         in   XLEN   PC of ID instruction
//  id_rs1_data   in   XLEN   register-file read data rs1
//  id_rs2_data   in   XLEN   register-file read data rs2
//  id_imm        in   XLEN   sign-extended immediate
//  id_rs1        in   5      rs1 index
//  id_rs2        in   5      rs2 index
//  id_rd         in   5      rd index
//  id_funct3     in   3      funct3
//  id_funct7     in   7      funct7
//  id_use_rs1    in   1      ID instruction reads rs1
//  id_use_rs2    in   1      ID instruction reads rs2
//  flush         in   1      kill ID instruction (EX redirect)
//  hold          in   1      freeze entire register (downstream stall)
//  ex_valid      out  1      EX slot holds real instruction
//  ex_ctrl       out  17     registered id_ctrl
//  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered copies
//  ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices
//  ex_funct3     out  3      registered funct3
//  ex_funct7     out  7      registered funct7
//  hazard_stall  out  1      combinational: hold PC and IF/ID this cycle
//  bubble_cnt    out  CNT_W  load-use bubbles inserted, saturating
// BEHAVIOUR
//  Reset: all ex_* outputs = 0 (ex_valid=0, ex_ctrl=0), bubble_cnt=0; hazard_stall follows its equation (0 after reset since ex_valid=0).
//  Hazard (comb): haz = ex_valid & ex_ctrl[3] & (ex_rd!=0) & id_valid &
//    ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
//  hazard_stall = haz & ~flush. hold does not mask hazard_stall.
//  Next-state priority per rising edge:
//   1. rst   -> clear as reset.
//   2. flush -> bubble: ex_valid=0, ex_ctrl=0; data fields don't-care (implement as 0). Overrides hold.
//   3. hold  -> all ex_* keep value; bubble_cnt unchanged.
//   4. haz   -> bubble (as 2); bubble_cnt += 1 unless all-ones (saturate).
//   5. else  -> load all id_* fields; ex_valid=id_valid; ex_ctrl = id_valid ? id_ctrl : 0.
//  Latency: one cycle ID->EX. Exactly one bubble per load-use: after bubble, ex_valid=0 so haz drops
//   and the held ID instruction advances next cycle.
//  Bubble ex_ctrl=0 guarantees no RegWriteEn/MemWriteEn/branch/jump side effects in EX.
//  rd==x0 never triggers hazard. Load followed by store using loaded value as rs2 still stalls (no MEM->MEM forward).
//  flush and haz same cycle: flush wins, counter not incremented, hazard_stall=0.
//  Reset asserted mid-stall: next cycle ex_valid=0, hazard_stall=0, counter 0.
// TESTING
//  1. rst=1 two cycles with random id_* -> all ex_* =0, bubble_cnt=0, hazard_stall=0.
//  2. id add x5,x1,x2 (ctrl=0x0001, pc=0x100) -> next cycle ex_valid=1, ex_ctrl=0x0001, ex_pc=0x100, ex_rd=5.
//  3. EX lw x5 (ctrl[3]=1, rd=5), ID add x6,x5,x7 use_rs1=1 -> hazard_stall=1; next: ex_valid=0, ex_ctrl=0,
//     bubble_cnt=1; following cycle add enters EX, hazard_stall=0.
//  4. Same as 3 with rd=0 -> hazard_stall=0, no bubble, count stays 0.
//  5. Hazard + flush=1 same cycle -> hazard_stall=0, EX bubble, bubble_cnt unchanged.
//  6. hold=1 3 cycles with changing id_* -> ex_* constant; force bubble_cnt to 0xFFFF via repeated
//     hazards -> stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with load-use hazard detection, single-bubble insertion,
// flush/hold control and a saturating count of inserted bubbles.
module id_ex_pipe_reg #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [16:0]      id_ctrl,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [2:0]       id_funct3,
   input  logic [6:0]       id_funct7,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             flush,
   input  logic             hold,
   output logic             ex_valid,
   output logic [16:0]      ex_ctrl,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [2:0]       ex_funct3,
   output logic [6:0]       ex_funct7,
   output logic             hazard_stall,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // ex_ctrl[3] is MemReadEn: a load in EX whose rd the ID instruction reads.
   logic ex_is_load;
   logic rs1_hit;
   logic rs2_hit;
   logic haz;

   always_comb begin
      ex_is_load   = ex_valid & ex_ctrl[3] & (ex_rd != 5'd0);
      rs1_hit      = id_use_rs1 & (ex_rd == id_rs1);
      rs2_hit      = id_use_rs2 & (ex_rd == id_rs2);
      haz          = ex_is_load & id_valid & (rs1_hit | rs2_hit);
      hazard_stall = haz & ~flush;
   end

   always_ff @(posedge clk) begin
      if (rst || flush || (!hold && haz)) begin
         // Reset, flush and load-use bubbles all present an empty, side-effect-free EX slot.
         ex_valid    <= 1'b0;
         ex_ctrl     <= '0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_funct3   <= '0;
         ex_funct7   <= '0;
      end else if (!hold) begin
         ex_valid    <= id_valid;
         ex_ctrl     <= id_valid ? id_ctrl : 17'd0;
         ex_pc       <= id_pc;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_funct3   <= id_funct3;
         ex_funct7   <= id_funct7;
      end
   end

   // Only a genuine load-use bubble counts; flush and hold take precedence.
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt <= '0;
      end else if (!flush && !hold && haz && (bubble_cnt != CNT_MAX)) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule
